// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with registered fill level, programmable almost-full/almost-empty
// thresholds, full headroom, optional first-word-fall-through reads and sticky errors.
module sync_fifo_flags #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 4,
  parameter int RESERVE       = 0,
  parameter int AFULL_THRESH  = (2 ** ADDR_WIDTH) - 2,
  parameter int AEMPTY_THRESH = 2,
  parameter int FWFT          = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic                  has_data,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int LW    = ADDR_WIDTH + 1;

  localparam logic [LW-1:0] FULL_AT = LW'(DEPTH - RESERVE);
  localparam logic [LW-1:0] AF_AT   = LW'(AFULL_THRESH);
  localparam logic [LW-1:0] AE_AT   = LW'(AEMPTY_THRESH);

  // Flag values for an empty FIFO, used on reset.
  localparam logic RST_FULL = ((DEPTH - RESERVE) <= 0);
  localparam logic RST_AF   = (AFULL_THRESH <= 0);
  localparam logic RST_AE   = (AEMPTY_THRESH >= 0);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  wr_acc;
  logic                  rd_acc;
  logic [LW-1:0]         next_level;

  // Handshake: a write transfers on an edge where wr_en is high and full is low,
  // a read where rd_en is high and empty is low; flush blocks both transfers.
  assign wr_acc   = wr_en & ~full & ~flush;
  assign rd_acc   = rd_en & ~empty & ~flush;
  assign has_data = ~empty;

  always_comb begin
    next_level = level;
    if (flush) begin
      next_level = '0;
    end else begin
      next_level = level + {{ADDR_WIDTH{1'b0}}, wr_acc} - {{ADDR_WIDTH{1'b0}}, rd_acc};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      full         <= RST_FULL;
      empty        <= 1'b1;
      almost_full  <= RST_AF;
      almost_empty <= RST_AE;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      level        <= next_level;
      full         <= (next_level >= FULL_AT);
      empty        <= (next_level == '0);
      almost_full  <= (next_level >= AF_AT);
      almost_empty <= (next_level <= AE_AT);
      if (flush) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end else begin
        if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
        if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
        if (wr_en && full) overflow <= 1'b1;
        if (rd_en && empty) underflow <= 1'b1;
      end
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= wr_data;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign rd_data = empty ? '0 : mem[rd_ptr];
    end else begin : g_std
      logic [DATA_WIDTH-1:0] rd_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd_q <= '0;
        end else if (rd_acc) begin
          rd_q <= mem[rd_ptr];
        end
      end
      assign rd_data = rd_q;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Drives one stimulus stream into three FIFO variants (default, RESERVE=4, FWFT=1)
// and compares every output each cycle against a queue-based reference model.
module tb_sync_fifo_flags;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int NI    = 3;

  logic clk;
  logic rst_n;
  logic flush;
  logic wr_en;
  logic rd_en;
  logic [DW-1:0] wr_data;

  logic [DW-1:0] rd_data      [NI];
  logic [AW:0]   level        [NI];
  logic          full         [NI];
  logic          empty        [NI];
  logic          has_data     [NI];
  logic          almost_full  [NI];
  logic          almost_empty [NI];
  logic          overflow     [NI];
  logic          underflow    [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    sync_fifo_flags #(
      .DATA_WIDTH(DW),
      .ADDR_WIDTH(AW),
      .RESERVE   ((g == 1) ? 4 : 0),
      .FWFT      ((g == 2) ? 1 : 0)
    ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush       (flush),
      .wr_en       (wr_en),
      .wr_data     (wr_data),
      .full        (full[g]),
      .rd_en       (rd_en),
      .rd_data     (rd_data[g]),
      .empty       (empty[g]),
      .has_data    (has_data[g]),
      .level       (level[g]),
      .almost_full (almost_full[g]),
      .almost_empty(almost_empty[g]),
      .overflow    (overflow[g]),
      .underflow   (underflow[g])
    );
  end

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  logic [DW-1:0] exp_q [NI][$];
  logic [DW-1:0] rdq_m [NI];
  logic          ovf_m [NI];
  logic          unf_m [NI];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int res_of(input int i);
    return (i == 1) ? 4 : 0;
  endfunction

  function automatic bit fwft_of(input int i);
    return (i == 2);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      exp_q[i].delete();
      rdq_m[i] = '0;
      ovf_m[i] = 1'b0;
      unf_m[i] = 1'b0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < NI; i++) begin
      int sz;
      bit m_full;
      bit m_empty;
      logic [DW-1:0] v;
      sz      = exp_q[i].size();
      m_full  = (sz >= DEPTH - res_of(i));
      m_empty = (sz == 0);
      if (flush) begin
        exp_q[i].delete();
        ovf_m[i] = 1'b0;
        unf_m[i] = 1'b0;
      end else begin
        if (wr_en && m_full)  ovf_m[i] = 1'b1;
        if (rd_en && m_empty) unf_m[i] = 1'b1;
        if (rd_en && !m_empty) begin
          v = exp_q[i].pop_front();
          if (!fwft_of(i)) rdq_m[i] = v;
        end
        if (wr_en && !m_full) exp_q[i].push_back(wr_data);
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < NI; i++) begin
      int sz;
      logic [DW-1:0] exp_rd;
      sz = exp_q[i].size();
      if (fwft_of(i)) exp_rd = (sz == 0) ? '0 : exp_q[i][0];
      else            exp_rd = rdq_m[i];
      check($sformatf("i%0d level", i),        32'(level[i]),        32'(sz));
      check($sformatf("i%0d full", i),         32'(full[i]),         32'(sz >= DEPTH - res_of(i)));
      check($sformatf("i%0d empty", i),        32'(empty[i]),        32'(sz == 0));
      check($sformatf("i%0d has_data", i),     32'(has_data[i]),     32'(sz != 0));
      check($sformatf("i%0d almost_full", i),  32'(almost_full[i]),  32'(sz >= DEPTH - 2));
      check($sformatf("i%0d almost_empty", i), 32'(almost_empty[i]), 32'(sz <= 2));
      check($sformatf("i%0d overflow", i),     32'(overflow[i]),     32'(ovf_m[i]));
      check($sformatf("i%0d underflow", i),    32'(underflow[i]),    32'(unf_m[i]));
      check($sformatf("i%0d rd_data", i),      32'(rd_data[i]),      32'(exp_rd));
    end
  endtask

  // driver: called just after a falling edge
  task automatic cycle(input logic w, input logic [DW-1:0] d, input logic r, input logic f);
    wr_en   = w;
    wr_data = d;
    rd_en   = r;
    flush   = f;
    @(posedge clk);
    model_step();
    #1;
    check_all();
    @(negedge clk);
  endtask

  task automatic idle();
    cycle(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic do_flush();
    cycle(1'b0, '0, 1'b0, 1'b1);
  endtask

  initial begin
    rst_n   = 1'b0;
    flush   = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    wr_data = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all();
    rst_n = 1'b1;
    idle();

    // fill past full then drain
    for (int k = 0; k < 16; k++) cycle(1'b1, DW'(k), 1'b0, 1'b0);
    check("t1 level16", 32'(level[0]), 32'd16);
    cycle(1'b1, 8'hEE, 1'b0, 1'b0);
    check("t1 overflow", 32'(overflow[0]), 32'd1);
    check("t4 full_at_12", 32'(level[1]), 32'd12);
    for (int k = 0; k < 16; k++) cycle(1'b0, '0, 1'b1, 1'b0);
    idle();

    // steady state streaming at level 8
    do_flush();
    for (int k = 0; k < 8; k++) cycle(1'b1, DW'(k), 1'b0, 1'b0);
    for (int k = 8; k < 108; k++) cycle(1'b1, DW'(k), 1'b1, 1'b0);
    check("t2 level8", 32'(level[0]), 32'd8);

    // simultaneous ops at full and at empty
    do_flush();
    for (int k = 0; k < 16; k++) cycle(1'b1, DW'(8'h40 + k), 1'b0, 1'b0);
    cycle(1'b1, 8'hDD, 1'b1, 1'b0);
    check("t3 level15", 32'(level[0]), 32'd15);
    for (int k = 0; k < 16; k++) cycle(1'b0, '0, 1'b1, 1'b0);
    do_flush();
    cycle(1'b1, 8'h77, 1'b1, 1'b0);
    check("t3 level1", 32'(level[0]), 32'd1);
    cycle(1'b0, '0, 1'b1, 1'b0);
    check("t3 read77", 32'(rd_data[0]), 32'h77);

    // fall-through visibility
    do_flush();
    cycle(1'b1, 8'hA5, 1'b0, 1'b0);
    check("t5 fwft_data", 32'(rd_data[2]), 32'hA5);
    cycle(1'b0, '0, 1'b1, 1'b0);
    check("t5 fwft_empty", 32'(empty[2]), 32'd1);

    // flush with coincident write
    for (int k = 0; k < 10; k++) cycle(1'b1, DW'(k), 1'b0, 1'b0);
    cycle(1'b1, 8'h99, 1'b0, 1'b1);
    check("t6 flush_level", 32'(level[0]), 32'd0);

    // randomized traffic with drifting bias
    for (int k = 0; k < 600; k++) begin
      int wb;
      wb = ((k / 100) % 2 == 0) ? 75 : 30;
      cycle(1'($urandom_range(0, 99) < wb), DW'($urandom),
            1'($urandom_range(0, 99) < 100 - wb),
            1'($urandom_range(0, 99) < 2));
    end

    // asynchronous reset mid-burst
    do_flush();
    for (int k = 0; k < 6; k++) cycle(1'b1, DW'(8'h30 + k), 1'b0, 1'b0);
    cycle(1'b1, 8'hFF, 1'b1, 1'b0);
    wr_en = 1'b1;
    rd_en = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    for (int i = 0; i < NI; i++) begin
      check($sformatf("rst i%0d level", i), 32'(level[i]),     32'd0);
      check($sformatf("rst i%0d empty", i), 32'(empty[i]),     32'd1);
      check($sformatf("rst i%0d rd", i),    32'(rd_data[i]),   32'd0);
      check($sformatf("rst i%0d ae", i),    32'(almost_empty[i]), 32'd1);
    end
    wr_en = 1'b0;
    rd_en = 1'b0;
    @(negedge clk);
    check_all();
    rst_n = 1'b1;
    idle();
    for (int k = 0; k < 5; k++) cycle(1'b1, DW'(8'hC0 + k), 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) cycle(1'b0, '0, 1'b1, 1'b0);
    check("rst last_read", 32'(rd_data[0]), 32'hC4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: got no end expected end by 200000");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
